// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the float-to-int conversion path.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_t;

  localparam int unsigned FP_BIAS    = 127;
  localparam int unsigned FP_EXP_MAX = 255;
  localparam logic [31:0] INT32_MAX  = 32'h7FFFFFFF;
  localparam logic [31:0] INT32_MIN  = 32'h80000000;

  typedef enum logic [1:0] {
    NORMAL,
    TINY,
    SAT,
    NAN
  } ftoi_cls_t;

endpackage

// File: rtl/ftoi_pipe_if.sv
// Handshake bundle for the float-to-int converter: issue side in, writeback side out.
interface ftoi_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/ftoi_decode.sv
// Combinational decode: classify the operand and align twice its magnitude (floored) into 33 bits.
module ftoi_decode
  import fpu_pkg::*;
(
  input  float_t      f_i,
  output logic [32:0] r_o,
  output ftoi_cls_t   cls_o
);

  localparam logic [7:0] ExpMax  = 8'(FP_EXP_MAX);
  localparam logic [7:0] ExpUnit = 8'(FP_BIAS + 23);  // shift of zero for {M,0}
  localparam logic [7:0] ExpSat  = 8'(FP_BIAS + 31);  // |x| >= 2^31
  localparam logic [7:0] ExpHalf = 8'(FP_BIAS - 1);   // |x| >= 0.5

  logic [32:0] wide;

  always_comb begin
    wide = {8'd0, 1'b1, f_i.man, 1'b0};
    r_o  = '0;
    if (f_i.exp < ExpUnit) begin
      r_o = wide >> (ExpUnit - f_i.exp);
    end else if (f_i.exp <= ExpSat) begin
      r_o = wide << (f_i.exp - ExpUnit);
    end
  end

  // -2^31 exactly is representable, so it stays on the normal path.
  always_comb begin
    if (f_i.exp == ExpMax) begin
      cls_o = (f_i.man != '0) ? NAN : SAT;
    end else if (f_i.exp >= ExpSat &&
                 !(f_i.sign && f_i.exp == ExpSat && f_i.man == '0)) begin
      cls_o = SAT;
    end else if (f_i.exp < ExpHalf) begin
      cls_o = TINY;
    end else begin
      cls_o = NORMAL;
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage float32 to int32 converter: decode/align, then round, apply sign and saturate.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned ROUND_NEAREST = 1,
  parameter logic [31:0] NAN_RESULT    = 32'h7FFFFFFF
) (
  input logic        clk,
  input logic        rstn,
  ftoi_pipe_if.slave bus
);

  logic        adv;
  float_t      in_f;
  logic [32:0] dec_r;
  ftoi_cls_t   dec_cls;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic [32:0] s1_r_q, s1_r_d;
  ftoi_cls_t   s1_cls_q, s1_cls_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_ovf_q, out_ovf_d;

  logic [32:0] r_sum;
  logic [31:0] mag;
  logic [31:0] res_data;
  logic        res_ovf;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign in_f         = bus.in_data;

  ftoi_decode u_decode (
    .f_i   (in_f),
    .r_o   (dec_r),
    .cls_o (dec_cls)
  );

  // R is twice the magnitude, so adding one before halving rounds ties away from zero.
  assign r_sum = s1_r_q + ((ROUND_NEAREST != 0) ? 33'd1 : 33'd0);
  assign mag   = r_sum[32:1];

  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    unique case (s1_cls_q)
      NAN: begin
        res_data = NAN_RESULT;
        res_ovf  = 1'b1;
      end
      SAT: begin
        res_data = s1_sign_q ? INT32_MIN : INT32_MAX;
        res_ovf  = 1'b1;
      end
      TINY:    res_data = '0;
      NORMAL:  res_data = s1_sign_q ? (~mag + 32'd1) : mag;
      default: res_data = '0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_r_d      = s1_r_q;
    s1_cls_d    = s1_cls_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (adv) begin
      s1_valid_d  = bus.in_valid;
      out_valid_d = s1_valid_q;
      if (bus.in_valid) begin
        s1_sign_d = in_f.sign;
        s1_r_d    = dec_r;
        s1_cls_d  = dec_cls;
      end
      if (s1_valid_q) begin
        out_data_d = res_data;
        out_ovf_d  = res_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_r_q      <= '0;
      s1_cls_q    <= NORMAL;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_r_q      <= s1_r_d;
      s1_cls_q    <= s1_cls_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench: a nearest-mode and a truncate-mode converter share one input stream.
module tb_ftoi_pipe;

  localparam logic [31:0] NAN_N = 32'h7FFFFFFF;
  localparam logic [31:0] NAN_T = 32'h0000DEAD;

  typedef struct {
    logic [31:0] din;
    logic [32:0] exp_n;
    logic [32:0] exp_t;
    int          acc;
    bit          lat;
  } entry_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rnd_ready = 1'b0;
  bit   lat_mode = 1'b0;
  entry_t sb[$];

  ftoi_pipe_if bif ();
  ftoi_pipe_if tif ();

  assign tif.in_valid  = bif.in_valid;
  assign tif.in_data   = bif.in_data;
  assign tif.out_ready = bif.out_ready;

  ftoi_pipe #(.ROUND_NEAREST(1), .NAN_RESULT(NAN_N)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  ftoi_pipe #(.ROUND_NEAREST(0), .NAN_RESULT(NAN_T)) u_trunc (
    .clk  (clk),
    .rstn (rstn),
    .bus  (tif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Value-level model: round the exact real value, then range-check it.
  function automatic logic [32:0] model(input logic [31:0] f, input bit nearest,
                                        input logic [31:0] nan_val);
    logic s;
    int ee, sh;
    longint unsigned mm, q, rem;
    longint v;
    logic [31:0] sat;
    s   = f[31];
    sat = s ? 32'h80000000 : 32'h7FFFFFFF;
    ee  = int'(f[30:23]);
    mm  = 64'(f[22:0]);
    if (ee == 255) return (f[22:0] != 0) ? {1'b1, nan_val} : {1'b1, sat};
    if (ee == 0) ee = 1;
    else mm = mm | 64'h800000;
    if (ee >= 150) begin
      q = (ee - 150 > 20) ? (64'd1 << 40) : (mm << (ee - 150));
    end else begin
      sh = 150 - ee;
      if (sh > 40) begin
        q = 0;
      end else begin
        q   = mm >> sh;
        rem = mm - (q << sh);
        if (nearest && rem >= (64'd1 << (sh - 1))) q = q + 1;
      end
    end
    v = s ? -longint'(q) : longint'(q);
    if (v > 64'sd2147483647 || v < -64'sd2147483648) return {1'b1, sat};
    return {1'b0, v[31:0]};
  endfunction

  function automatic logic [31:0] int_to_float(input int k);
    logic [31:0] a;
    int p;
    if (k == 0) return 32'h0;
    a = (k < 0) ? 32'(-k) : 32'(k);
    p = 0;
    for (int i = 0; i < 32; i++) if (a[i]) p = i;
    return {(k < 0), 8'(127 + p), 23'((a << (23 - p)) & 32'h7FFFFF)};
  endfunction

  task automatic send(input logic [31:0] d);
    int tries = 0;
    if (!lat_mode && $urandom_range(3) == 0) begin
      @(posedge clk);
      #1;
      bif.in_valid  = 1'b0;
      bif.out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
    end
    forever begin
      @(posedge clk);
      #1;
      bif.in_valid  = 1'b1;
      bif.in_data   = d;
      bif.out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk);
      if (bif.in_ready) begin
        sb.push_back('{din: d, exp_n: model(d, 1'b1, NAN_N), exp_t: model(d, 1'b0, NAN_T),
                       acc: cyc, lat: lat_mode});
        break;
      end
      tries++;
      if (tries > 1000) begin
        errors++;
        $display("FAIL accept_timeout: in_ready stuck low, got 0 need 1");
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, need 0", sb.size());
    end
  endtask

  // Monitor: compare on every consumed output, and check stability across stalls.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_ovf;
  always @(negedge clk) begin
    entry_t e;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!bif.out_valid || bif.out_data !== prev_data || bif.out_ovf !== prev_ovf) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h/%0b need v=1 %h/%0b", bif.out_valid,
                   bif.out_data, bif.out_ovf, prev_data, prev_ovf);
        end
      end
      prev_stall = bif.out_valid && !bif.out_ready;
      prev_data  = bif.out_data;
      prev_ovf   = bif.out_ovf;
      checks++;
      if (tif.out_valid !== bif.out_valid) begin
        errors++;
        $display("FAIL trunc_valid: got %0b need %0b", tif.out_valid, bif.out_valid);
      end
      if (bif.out_valid && bif.out_ready) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_output: got %h, need no output", bif.out_data);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({bif.out_ovf, bif.out_data} !== e.exp_n) begin
            errors++;
            $display("FAIL nearest in=%h: got ovf=%0b %h need ovf=%0b %h", e.din, bif.out_ovf,
                     bif.out_data, e.exp_n[32], e.exp_n[31:0]);
          end
          checks++;
          if ({tif.out_ovf, tif.out_data} !== e.exp_t) begin
            errors++;
            $display("FAIL trunc in=%h: got ovf=%0b %h need ovf=%0b %h", e.din, tif.out_ovf,
                     tif.out_data, e.exp_t[32], e.exp_t[31:0]);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.acc != 2) begin
              errors++;
              $display("FAIL latency in=%h: got %0d edges need 2", e.din, cyc - e.acc);
            end
          end
        end
      end
    end
  end

  logic [31:0] directed[] = '{
    32'h3FC00000, 32'hC0200000, 32'h3EFFFFFF, 32'h3F000000, 32'h4F000000, 32'hCF000000,
    32'hCF000001, 32'h4EFFFFFF, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h80000000,
    32'h00000001, 32'hBF000000, 32'h4B7FFFFF, 32'h7F800001
  };

  initial begin
    logic [31:0] f;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_data !== 32'h0 || bif.out_ovf !== 1'b0 ||
        bif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%0b d=%h o=%0b r=%0b need 0 0 0 1", bif.out_valid,
               bif.out_data, bif.out_ovf, bif.in_ready);
    end
    rstn = 1'b1;

    // Directed values, back-to-back, with latency checked.
    lat_mode = 1'b1;
    foreach (directed[i]) send(directed[i]);
    drain();
    lat_mode = 1'b0;

    // Integer stream with random backpressure.
    rnd_ready = 1'b1;
    for (int k = -100; k < 100; k++) send(int_to_float(k));
    // Random operands, biased to the interesting exponent window, plus exact ties.
    for (int i = 0; i < 300; i++) begin
      f = $urandom;
      if (i % 4 != 0) f[30:23] = 8'($urandom_range(165, 118));
      send(f);
    end
    for (int i = 0; i < 60; i++) begin
      f = int_to_float(2 * int'($urandom_range(1000)) + 1);
      f[30:23] = f[30:23] - 8'd1;
      f[31] = 1'($urandom_range(1));
      send(f);
    end
    drain();

    // Fill both stages under stall, then reset asynchronously mid-cycle.
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_data   = 32'h40400000;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (bif.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL prefill: got out_valid=%0b need 1", bif.out_valid);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_data !== 32'h0 || tif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%0b d=%h tv=%0b need 0 0 0", bif.out_valid,
               bif.out_data, tif.out_valid);
    end
    sb.delete();
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    lat_mode = 1'b1;
    send(32'hC0200000);
    send(32'h3FC00000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got timeout need finish");
    $fatal(1, "timeout");
  end

endmodule
